mult_sequencer: RTL

Multi-cycle MULT/MULTU sequencer for the processor's multiply path; it borrows the shared 32-bit ALU for its adds instead of using a dedicated adder. It performs radix-2 shift-add multiplication, one ALU add per granted cycle. It requests the ALU through a req/gnt handshake with the datapath arbiter. The 64-bit product goes to the HI/LO registers.

---
 rtl/mult_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
// Radix-2 shift-add MULT/MULTU sequencer that borrows the shared ALU for one add per granted cycle.
// Signed MULT support (operand magnitudes plus the FIX negate state) is built only when MULT_SEQ_SIGNED_EN is defined.
module mult_sequencer #(
    parameter int         DATA_W  = 32,
    parameter logic [3:0] ALU_ADD = 4'b0010
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              alu_req,
    input  logic              alu_gnt,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] acc_hi_q;
    logic [DATA_W-1:0] acc_lo_q;
    logic [DATA_W-1:0] mcand_q;
    logic [5:0]        cnt_q;
    logic              done_q;
    logic              alu_req_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic [DATA_W-1:0]   mag_a_d;
    logic [DATA_W-1:0]   mag_b_d;
    logic                carry_d;
    logic [2*DATA_W-1:0] step_d;

`ifdef MULT_SEQ_SIGNED_EN
    logic neg_q;
    logic neg_d;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign mag_a_d = (is_signed && op_a[DATA_W-1]) ? -op_a : op_a;
    assign mag_b_d = (is_signed && op_b[DATA_W-1]) ? -op_b : op_b;
    assign neg_d   = is_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign mag_a_d          = op_a;
    assign mag_b_d          = op_b;
`endif

    // The shared ALU only returns 32 bits, so the add carry is recovered by wrap-around compare.
    assign carry_d = (alu_out < acc_hi_q);
    assign step_d  = {carry_d, alu_out, acc_lo_q[DATA_W-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            alu_req_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef MULT_SEQ_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_hi_q  <= '0;
                        acc_lo_q  <= mag_b_d;
                        mcand_q   <= mag_a_d;
                        cnt_q     <= '0;
                        alu_req_q <= 1'b1;
                        state_q   <= CALC;
`ifdef MULT_SEQ_SIGNED_EN
                        neg_q     <= neg_d;
`endif
                    end
                end
                CALC: begin
                    if (alu_gnt) begin
                        {acc_hi_q, acc_lo_q} <= step_d;
                        cnt_q                <= cnt_q + 6'd1;
                        if (cnt_q == 6'(DATA_W - 1)) begin
                            alu_req_q <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
                            state_q   <= neg_q ? FIX : DONE;
`else
                            state_q   <= DONE;
`endif
                        end
                    end
                end
`ifdef MULT_SEQ_SIGNED_EN
                FIX: begin
                    {acc_hi_q, acc_lo_q} <= -{acc_hi_q, acc_lo_q};
                    state_q              <= DONE;
                end
`endif
                DONE: begin
                    hi_q    <= acc_hi_q;
                    lo_q    <= acc_lo_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    alu_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // ALU operands are driven from registers only, so alu_gnt never loops back into them.
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign alu_req  = alu_req_q;
    assign alu_in1  = alu_req_q ? acc_hi_q : '0;
    assign alu_in2  = (alu_req_q && acc_lo_q[0]) ? mcand_q : '0;
    assign alu_ctrl = alu_req_q ? ALU_ADD : 4'b0000;

endmodule
